// File: rtl/uart_imem_loader_if.sv
// UART receive side and IMEM write / status side of the boot loader.
interface uart_imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_break;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              write_done;
  logic              cpu_rst;
  logic [ADDR_W:0]   word_count;
  logic              overflow;
  logic              timeout_err;

  modport master (
    input  rx_valid, rx_data, rx_break,
    output imem_we, imem_addr, imem_wdata, write_done, cpu_rst,
           word_count, overflow, timeout_err
  );

  modport slave (
    output rx_valid, rx_data, rx_break,
    input  imem_we, imem_addr, imem_wdata, write_done, cpu_rst,
           word_count, overflow, timeout_err
  );
endinterface

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes LSB-first into 32-bit words, writes them to
// consecutive IMEM addresses and releases the core after the end marker.
module uart_imem_loader #(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] END_MARKER  = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input logic               clk,
  input logic               rst,
  uart_imem_loader_if.master bus
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W:0]   CNT_MAX   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t            state, state_next;
  logic [1:0]        k;
  logic [31:0]       shift;
  logic [31:0]       word;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   cnt;
  logic [TMR_W-1:0]  timer;
  logic              ovf;
  logic              tmo;
  logic [31:0]       full_word;

  assign full_word = {bus.rx_data, shift[23:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_COLLECT;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    bus.imem_we    = 1'b0;
    bus.write_done = 1'b0;
    bus.cpu_rst    = 1'b1;
    case (state)
      S_COLLECT: begin
        if (bus.rx_valid && !bus.rx_break && k == 2'd3)
          state_next = (full_word == END_MARKER) ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        bus.imem_we = 1'b1;
        state_next  = (addr == ADDR_LAST) ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        bus.write_done = 1'b1;
        bus.cpu_rst    = 1'b0;
      end
      default: state_next = S_COLLECT;
    endcase
  end

  // Break takes priority over a coincident byte; a byte beats timer expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      shift <= '0;
      word  <= '0;
      addr  <= '0;
      cnt   <= '0;
      timer <= '0;
      ovf   <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (bus.rx_break) begin
            k     <= '0;
            shift <= '0;
            timer <= '0;
          end else if (bus.rx_valid) begin
            shift[{k, 3'b000} +: 8] <= bus.rx_data;
            k     <= k + 2'd1;
            timer <= '0;
            if (k == 2'd3) word <= full_word;
          end else if (k != 2'd0) begin
            if (timer == TMR_LAST) begin
              k     <= '0;
              shift <= '0;
              timer <= '0;
              tmo   <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (addr == ADDR_LAST) ovf  <= 1'b1;
          else                   addr <= addr + 1'b1;
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          timer <= '0;
          // A byte arriving during the write cycle starts the next word.
          if (bus.rx_valid) begin
            shift <= {24'd0, bus.rx_data};
            k     <= 2'd1;
          end else begin
            shift <= '0;
            k     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_addr   = addr;
  assign bus.imem_wdata  = word;
  assign bus.word_count  = cnt;
  assign bus.overflow    = ovf;
  assign bus.timeout_err = tmo;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: expected IMEM writes are queued as
// bytes are driven and popped as write pulses appear.
module tb_uart_imem_loader;

  localparam int          TO     = 20;
  localparam logic [31:0] MARKER = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;

  uart_imem_loader_if #(.ADDR_W(8)) bif ();
  uart_imem_loader_if #(.ADDR_W(2)) bif2 ();

  uart_imem_loader #(.ADDR_W(8), .END_MARKER(MARKER), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  uart_imem_loader #(.ADDR_W(2), .END_MARKER(MARKER), .TIMEOUT_CYC(TO)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bif2)
  );

  int errors = 0;
  int checks = 0;
  int wr1    = 0;
  int wr2    = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int addr1 = 0;
  int addr2 = 0;
  bit done1 = 0;
  bit full2 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bif.imem_we === 1'b1) begin
      wr1++;
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write1 got addr=%h data=%h exp no write", bif.imem_addr, bif.imem_wdata);
      end else begin
        e1 = q1.pop_front();
        if (bif.imem_addr !== e1.addr[7:0] || bif.imem_wdata !== e1.data) begin
          errors++;
          $display("FAIL write1 got addr=%h data=%h exp addr=%h data=%h",
                   bif.imem_addr, bif.imem_wdata, e1.addr[7:0], e1.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bif2.imem_we === 1'b1) begin
      wr2++;
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write2 got addr=%h data=%h exp no write", bif2.imem_addr, bif2.imem_wdata);
      end else begin
        e2 = q2.pop_front();
        if (bif2.imem_addr !== e2.addr[1:0] || bif2.imem_wdata !== e2.data) begin
          errors++;
          $display("FAIL write2 got addr=%h data=%h exp addr=%h data=%h",
                   bif2.imem_addr, bif2.imem_wdata, e2.addr[1:0], e2.data);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    addr1 = 0; addr2 = 0; done1 = 0; full2 = 0;
  endtask

  task automatic send_byte(input int which, input logic [7:0] b);
    @(negedge clk);
    if (which == 1) begin bif.rx_valid = 1'b1;  bif.rx_data = b;  end
    else            begin bif2.rx_valid = 1'b1; bif2.rx_data = b; end
    @(negedge clk);
    bif.rx_valid  = 1'b0;
    bif2.rx_valid = 1'b0;
  endtask

  task automatic send_word(input int which, input logic [31:0] w);
    if (which == 1) begin
      if (!done1) begin
        if (w == MARKER) done1 = 1;
        else begin q1.push_back('{32'(addr1), w}); addr1++; end
      end
    end else begin
      if (!full2 && w != MARKER) begin
        q2.push_back('{32'(addr2), w});
        addr2++;
        if (addr2 == 4) full2 = 1;
      end
    end
    for (int i = 0; i < 4; i++) send_byte(which, w[8*i +: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bif.imem_we !== 1'b0)       begin errors++; $display("FAIL rst_we got=%b exp=0", bif.imem_we); end
    checks++; if (bif.imem_addr !== 8'd0)     begin errors++; $display("FAIL rst_addr got=%h exp=0", bif.imem_addr); end
    checks++; if (bif.imem_wdata !== 32'd0)   begin errors++; $display("FAIL rst_wdata got=%h exp=0", bif.imem_wdata); end
    checks++; if (bif.write_done !== 1'b0)    begin errors++; $display("FAIL rst_done got=%b exp=0", bif.write_done); end
    checks++; if (bif.cpu_rst !== 1'b1)       begin errors++; $display("FAIL rst_cpu_rst got=%b exp=1", bif.cpu_rst); end
    checks++; if (bif.word_count !== 9'd0)    begin errors++; $display("FAIL rst_count got=%0d exp=0", bif.word_count); end
    checks++; if (bif.overflow !== 1'b0)      begin errors++; $display("FAIL rst_ovf got=%b exp=0", bif.overflow); end
    checks++; if (bif.timeout_err !== 1'b0)   begin errors++; $display("FAIL rst_tmo got=%b exp=0", bif.timeout_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_byte_order();
    do_reset();
    q1.push_back('{32'd0, 32'hfb01_0113});
    addr1 = 1;
    send_byte(1, 8'h13);
    send_byte(1, 8'h01);
    send_byte(1, 8'h01);
    @(negedge clk);
    bif.rx_valid = 1'b1; bif.rx_data = 8'hfb;
    @(negedge clk);
    bif.rx_valid = 1'b0;
    checks++; if (bif.imem_we !== 1'b1) begin errors++; $display("FAIL order_latency got we=%b exp=1", bif.imem_we); end
    @(negedge clk);
    checks++; if (bif.imem_we !== 1'b0) begin errors++; $display("FAIL order_pulse got we=%b exp=0", bif.imem_we); end
    checks++; if (bif.word_count !== 9'd1) begin errors++; $display("FAIL order_count got=%0d exp=1", bif.word_count); end
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL order_drain got=%0d pending exp=0", q1.size()); end
  endtask

  task automatic test_load();
    do_reset();
    send_word(1, 32'h0000_0000);
    send_word(1, 32'hfb01_0113);
    send_word(1, 32'h0481_2623);
    send_word(1, MARKER);
    repeat (3) @(negedge clk);
    checks++; if (bif.write_done !== 1'b1) begin errors++; $display("FAIL load_done got=%b exp=1", bif.write_done); end
    checks++; if (bif.cpu_rst !== 1'b0)    begin errors++; $display("FAIL load_cpu_rst got=%b exp=0", bif.cpu_rst); end
    checks++; if (bif.word_count !== 9'd3) begin errors++; $display("FAIL load_count got=%0d exp=3", bif.word_count); end
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL load_drain got=%0d pending exp=0", q1.size()); end
  endtask

  task automatic test_done_ignore();
    int w0;
    w0 = wr1;
    for (int i = 0; i < 8; i++) send_byte(1, 8'(8'h30 + i));
    @(negedge clk); bif.rx_break = 1'b1;
    @(negedge clk); bif.rx_break = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr1 != w0)               begin errors++; $display("FAIL done_writes got=%0d exp=%0d", wr1, w0); end
    checks++; if (bif.write_done !== 1'b1) begin errors++; $display("FAIL done_done got=%b exp=1", bif.write_done); end
    checks++; if (bif.cpu_rst !== 1'b0)    begin errors++; $display("FAIL done_cpu_rst got=%b exp=0", bif.cpu_rst); end
    checks++; if (bif.word_count !== 9'd3) begin errors++; $display("FAIL done_count got=%0d exp=3", bif.word_count); end
    checks++; if (bif.overflow !== 1'b0)   begin errors++; $display("FAIL done_ovf got=%b exp=0", bif.overflow); end
    checks++; if (bif.timeout_err !== 1'b0) begin errors++; $display("FAIL done_tmo got=%b exp=0", bif.timeout_err); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(1, 8'haa);
    send_byte(1, 8'hbb);
    repeat (TO - 1) @(negedge clk);
    checks++; if (bif.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early got=%b exp=0", bif.timeout_err); end
    @(negedge clk);
    checks++; if (bif.timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_flag got=%b exp=1", bif.timeout_err); end
    send_word(1, 32'h00ef_6f33);
    repeat (2) @(negedge clk);
    checks++; if (bif.word_count !== 9'd1) begin errors++; $display("FAIL tmo_count got=%0d exp=1", bif.word_count); end
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL tmo_drain got=%0d pending exp=0", q1.size()); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] bytes;
    do_reset();
    bytes = 64'h0102_0304_0a0b_0c0d;
    q1.push_back('{32'd0, 32'h0a0b_0c0d});
    q1.push_back('{32'd1, 32'h0102_0304});
    addr1 = 2;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bif.rx_valid = 1'b1;
      bif.rx_data  = bytes[8*i +: 8];
      @(negedge clk);
    end
    bif.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bif.word_count !== 9'd2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", bif.word_count); end
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL b2b_drain got=%0d pending exp=0", q1.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(1, 32'ha5a5_0001);
    send_byte(1, 8'h77);
    send_byte(1, 8'h88);
    repeat (2) @(negedge clk);
    checks++; if (bif.imem_addr !== 8'd1) begin errors++; $display("FAIL mid_pre_addr got=%h exp=1", bif.imem_addr); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bif.cpu_rst !== 1'b1)     begin errors++; $display("FAIL mid_cpu_rst got=%b exp=1", bif.cpu_rst); end
    checks++; if (bif.word_count !== 9'd0)  begin errors++; $display("FAIL mid_count got=%0d exp=0", bif.word_count); end
    checks++; if (bif.imem_addr !== 8'd0)   begin errors++; $display("FAIL mid_addr got=%h exp=0", bif.imem_addr); end
    checks++; if (bif.imem_wdata !== 32'd0) begin errors++; $display("FAIL mid_wdata got=%h exp=0", bif.imem_wdata); end
    #1 rst = 1'b0;
    addr1 = 0;
    send_word(1, 32'h1234_5678);
    repeat (2) @(negedge clk);
    checks++; if (bif.word_count !== 9'd1) begin errors++; $display("FAIL mid_post_count got=%0d exp=1", bif.word_count); end
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL mid_drain got=%0d pending exp=0", q1.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_word(2, 32'h1111_1111);
    send_word(2, 32'h2222_2222);
    send_word(2, 32'h3333_3333);
    send_word(2, 32'h4444_4444);
    send_word(2, 32'h5555_5555);
    repeat (3) @(negedge clk);
    checks++; if (wr2 != 4)                 begin errors++; $display("FAIL ovf_writes got=%0d exp=4", wr2); end
    checks++; if (bif2.overflow !== 1'b1)   begin errors++; $display("FAIL ovf_flag got=%b exp=1", bif2.overflow); end
    checks++; if (bif2.write_done !== 1'b1) begin errors++; $display("FAIL ovf_done got=%b exp=1", bif2.write_done); end
    checks++; if (bif2.cpu_rst !== 1'b0)    begin errors++; $display("FAIL ovf_cpu_rst got=%b exp=0", bif2.cpu_rst); end
    checks++; if (bif2.word_count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", bif2.word_count); end
    checks++; if (q2.size() != 0) begin errors++; $display("FAIL ovf_drain got=%0d pending exp=0", q2.size()); end
  endtask

  initial begin
    bif.rx_valid = 1'b0;  bif.rx_data = '0;  bif.rx_break = 1'b0;
    bif2.rx_valid = 1'b0; bif2.rx_data = '0; bif2.rx_break = 1'b0;
    test_reset();
    test_byte_order();
    test_load();
    test_done_ignore();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
